// File: rtl/estado_mascota.sv
// estado_mascota: pet-state decision stage.
// Resolves one registered pet state from the four need levels. A new state
// needs a persistence filter to commit. Starvation plus sickness leads to an
// absorbing MUERTO state. Registered enables are driven back to the level
// block.
// Optional feature macro: MASCOTA_TEST_EN. When it is defined, a rising edge
// on Test advances the state and freezes evaluation for TEST_HOLD edges.
module estado_mascota #(
    parameter int PERSIST   = 4,
    parameter int DEATH_CYC = 16,
    parameter int TEST_HOLD = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Test,
    input  logic [0:1] Nivel_Animo,
    input  logic [0:1] Nivel_Energia,
    input  logic [0:1] Nivel_Descanso,
    input  logic [0:1] Nivel_Medicina,
    output logic [2:0] Estado,
    output logic       Activo_Comida,
    output logic       Activo_Medicina,
    output logic       Cambio_Estado
);

    localparam logic [2:0] FELIZ      = 3'd0;
    localparam logic [2:0] TRISTE     = 3'd1;
    localparam logic [2:0] HAMBRIENTO = 3'd2;
    localparam logic [2:0] DORMIDO    = 3'd3;
    localparam logic [2:0] ENFERMO    = 3'd4;
    localparam logic [2:0] MUERTO     = 3'd7;

    localparam int PW = $clog2(PERSIST + 1);
    localparam int DW = $clog2(DEATH_CYC + 1);

    logic [2:0]    estado_q, estado_d;
    logic [2:0]    cand_q, cand_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          comida_q, comida_d;
    logic          medicina_q, medicina_d;
    logic          cambio_q, cambio_d;

    logic [2:0]    cand;
    logic          starving;
    logic [2:0]    p_estado;
    logic [PW-1:0] p_cnt;
    logic [PW-1:0] p_next;

`ifdef MASCOTA_TEST_EN
    localparam int HW = $clog2(TEST_HOLD + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          test_q, test_d;
    logic          test_rise;

    // Fixed advance order used by the Test button.
    function automatic logic [2:0] next_in_cycle(input logic [2:0] s);
        case (s)
            FELIZ:      next_in_cycle = TRISTE;
            TRISTE:     next_in_cycle = HAMBRIENTO;
            HAMBRIENTO: next_in_cycle = DORMIDO;
            DORMIDO:    next_in_cycle = ENFERMO;
            default:    next_in_cycle = FELIZ;
        endcase
    endfunction

    assign test_rise = Test & ~test_q;
`else
    // Without the test feature the button and the hold length have no effect.
    localparam int unused_test_hold = TEST_HOLD;
    logic unused_test;
    assign unused_test = Test;
`endif

    assign starving = (Nivel_Energia == 2'd0) && (Nivel_Medicina == 2'd0);

    // Candidate state from the need levels. The first match wins, and DORMIDO has exit hysteresis.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        cand = FELIZ;
        if (Nivel_Medicina == 2'd0) begin
            cand = ENFERMO;
        end else if ((Nivel_Descanso == 2'd0) ||
                     ((estado_q == DORMIDO) && (Nivel_Descanso < 2'd2))) begin
            cand = DORMIDO;
        end else if (Nivel_Energia == 2'd0) begin
            cand = HAMBRIENTO;
        end else if (Nivel_Animo == 2'd0) begin
            cand = TRISTE;
        end
    end

    // Persistence filter: commit the candidate on its PERSIST-th consecutive differing edge.
    always_comb begin
        p_estado = estado_q;
        p_cnt    = '0;
        p_next   = '0;
        if (cand != estado_q) begin
            p_next = (cand != cand_q) ? PW'(1) : (pcnt_q + PW'(1));
            if (p_next == PW'(PERSIST)) begin
                p_estado = cand;
            end else begin
                p_cnt = p_next;
            end
        end
    end

    // Next-state resolution. Order: MUERTO absorbs, then death, invalid code, test advance, hold, persist.
    always_comb begin
        estado_d = estado_q;
        cand_d   = cand_q;
        pcnt_d   = pcnt_q;
        dcnt_d   = dcnt_q;
`ifdef MASCOTA_TEST_EN
        hold_d   = hold_q;
        test_d   = test_q;
`endif
        if (estado_q != MUERTO) begin
            if (!starving) begin
                dcnt_d = '0;
            end else if (dcnt_q != DW'(DEATH_CYC)) begin
                dcnt_d = dcnt_q + DW'(1);
            end
`ifdef MASCOTA_TEST_EN
            test_d = Test;
            if (hold_q != '0) begin
                hold_d = hold_q - HW'(1);
            end
`endif
            if (starving && (dcnt_q == DW'(DEATH_CYC - 1))) begin
                estado_d = MUERTO;
                pcnt_d   = '0;
            end else if ((estado_q == 3'd5) || (estado_q == 3'd6)) begin
                estado_d = FELIZ;
                cand_d   = cand;
                pcnt_d   = '0;
`ifdef MASCOTA_TEST_EN
            end else if (test_rise) begin
                estado_d = next_in_cycle(estado_q);
                cand_d   = cand;
                pcnt_d   = '0;
                hold_d   = HW'(TEST_HOLD);
            end else if (hold_q != '0) begin
                // Frozen: candidate history and persist count are held.
                cand_d   = cand_q;
`endif
            end else begin
                estado_d = p_estado;
                cand_d   = cand;
                pcnt_d   = p_cnt;
            end
        end
    end

    // Enables and the change pulse follow the next state so they update together with Estado.
    always_comb begin
        comida_d   = (estado_d != DORMIDO) && (estado_d != MUERTO);
        medicina_d = (estado_d == ENFERMO);
        cambio_d   = (estado_d != estado_q);
    end

    // State and output registers, asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q   <= FELIZ;
            cand_q     <= FELIZ;
            pcnt_q     <= '0;
            dcnt_q     <= '0;
            comida_q   <= 1'b1;
            medicina_q <= 1'b0;
            cambio_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            estado_q   <= estado_d;
            cand_q     <= cand_d;
            pcnt_q     <= pcnt_d;
            dcnt_q     <= dcnt_d;
            comida_q   <= comida_d;
            medicina_q <= medicina_d;
            cambio_q   <= cambio_d;
        end
    end

`ifdef MASCOTA_TEST_EN
    // Test edge register and hold counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            test_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            test_q <= test_d;
        end
    end
`endif

    assign Estado          = estado_q;
    assign Activo_Comida   = comida_q;
    assign Activo_Medicina = medicina_q;
    assign Cambio_Estado   = cambio_q;

endmodule

// File: tb/tb_estado_mascota.sv
// Self-checking bench for estado_mascota with default parameters
// (PERSIST=4, DEATH_CYC=16, TEST_HOLD=32). Expected output vectors
// {Estado, Activo_Comida, Activo_Medicina, Cambio_Estado} are queued per
// clock edge when stimulus is applied and compared one per edge.
module tb_estado_mascota;

    localparam logic [2:0] FELIZ      = 3'd0;
    localparam logic [2:0] TRISTE     = 3'd1;
    localparam logic [2:0] HAMBRIENTO = 3'd2;
    localparam logic [2:0] DORMIDO    = 3'd3;
    localparam logic [2:0] ENFERMO    = 3'd4;
    localparam logic [2:0] MUERTO     = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic       test_btn;
    logic [0:1] nivel_animo, nivel_energia, nivel_descanso, nivel_medicina;
    logic [2:0] estado;
    logic       activo_comida, activo_medicina, cambio_estado;

    logic [5:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    estado_mascota dut (
        .clk             (clk),
        .reset           (reset),
        .Test            (test_btn),
        .Nivel_Animo     (nivel_animo),
        .Nivel_Energia   (nivel_energia),
        .Nivel_Descanso  (nivel_descanso),
        .Nivel_Medicina  (nivel_medicina),
        .Estado          (estado),
        .Activo_Comida   (activo_comida),
        .Activo_Medicina (activo_medicina),
        .Cambio_Estado   (cambio_estado)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ex(input logic [2:0] s, input logic c);
        ex = {s, (s != DORMIDO) && (s != MUERTO), (s == ENFERMO), c};
    endfunction

    function automatic logic [5:0] obs();
        obs = {estado, activo_comida, activo_medicina, cambio_estado};
    endfunction

    // Queue n expected per-edge vectors.
    task automatic push(input logic [2:0] s, input logic c, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ex(s, c));
    endtask

    task automatic set_levels(input logic [1:0] a, input logic [1:0] e,
                              input logic [1:0] d, input logic [1:0] m);
        nivel_animo = a; nivel_energia = e; nivel_descanso = d; nivel_medicina = m;
    endtask

    task automatic test_reset;
        logic [5:0] e;
        int idx;
        reset = 1'b0; test_btn = 1'b0;
        set_levels(2'd3, 2'd3, 2'd3, 2'd3);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== ex(FELIZ, 1'b0)) begin
            n_bad++;
            $display("FAIL reset_hold: got %b, expected %b", obs(), ex(FELIZ, 1'b0));
        end
        @(negedge clk) reset = 1'b1;
        push(FELIZ, 1'b0, 4);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL reset_release[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
    endtask

    task automatic test_triste;
        logic [5:0] e;
        int idx;
        set_levels(2'd0, 2'd3, 2'd3, 2'd3);
        push(FELIZ, 1'b0, 3); push(TRISTE, 1'b1, 1); push(TRISTE, 1'b0, 2);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL triste_enter[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
        set_levels(2'd3, 2'd3, 2'd3, 2'd3);
        push(TRISTE, 1'b0, 3); push(FELIZ, 1'b1, 1); push(FELIZ, 1'b0, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL triste_exit[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
    endtask

    task automatic test_glitch;
        logic [5:0] e;
        int idx;
        set_levels(2'd0, 2'd3, 2'd3, 2'd3);
        push(FELIZ, 1'b0, 3);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL glitch_low[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
        set_levels(2'd3, 2'd3, 2'd3, 2'd3);
        push(FELIZ, 1'b0, 6);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL glitch_back[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
    endtask

    task automatic test_dormido;
        logic [5:0] e;
        int idx;
        for (int step = 0; step < 3; step++) begin
            case (step)
                0: begin
                    set_levels(2'd3, 2'd3, 2'd0, 2'd3);
                    push(FELIZ, 1'b0, 3); push(DORMIDO, 1'b1, 1); push(DORMIDO, 1'b0, 1);
                end
                1: begin
                    set_levels(2'd3, 2'd3, 2'd1, 2'd3);
                    push(DORMIDO, 1'b0, 6);
                end
                default: begin
                    set_levels(2'd3, 2'd3, 2'd2, 2'd3);
                    push(DORMIDO, 1'b0, 3); push(FELIZ, 1'b1, 1); push(FELIZ, 1'b0, 1);
                end
            endcase
            idx = 0;
            while (exp_q.size() > 0) begin
                @(posedge clk); #1;
                e = exp_q.pop_front();
                n_cmp++;
                if (obs() !== e) begin
                    n_bad++;
                    $display("FAIL dormido_step%0d[%0d]: got %b, expected %b", step, idx, obs(), e);
                end
                idx++;
            end
        end
    endtask

    task automatic test_enfermo_priority;
        logic [5:0] e;
        int idx;
        set_levels(2'd3, 2'd3, 2'd0, 2'd0);
        push(FELIZ, 1'b0, 3); push(ENFERMO, 1'b1, 1); push(ENFERMO, 1'b0, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL enfermo_enter[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
        set_levels(2'd3, 2'd3, 2'd3, 2'd3);
        push(ENFERMO, 1'b0, 3); push(FELIZ, 1'b1, 1); push(FELIZ, 1'b0, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL enfermo_exit[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
    endtask

    // The candidate changes mid-count, so the persist count restarts from 1.
    task automatic test_back_to_back;
        logic [5:0] e;
        int idx;
        set_levels(2'd0, 2'd3, 2'd3, 2'd3);
        push(FELIZ, 1'b0, 2);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL b2b_first[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
        set_levels(2'd0, 2'd0, 2'd3, 2'd3);
        push(FELIZ, 1'b0, 3); push(HAMBRIENTO, 1'b1, 1); push(HAMBRIENTO, 1'b0, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL b2b_second[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
        set_levels(2'd3, 2'd3, 2'd3, 2'd3);
        push(HAMBRIENTO, 1'b0, 3); push(FELIZ, 1'b1, 1); push(FELIZ, 1'b0, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL b2b_restore[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
    endtask

    // Reset between edges discards a partial persist count.
    task automatic test_reset_mid;
        logic [5:0] e;
        int idx;
        set_levels(2'd0, 2'd3, 2'd3, 2'd3);
        push(FELIZ, 1'b0, 2);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL midreset_pre[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
        reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        push(FELIZ, 1'b0, 3); push(TRISTE, 1'b1, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL midreset_post[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
        set_levels(2'd3, 2'd3, 2'd3, 2'd3);
        push(TRISTE, 1'b0, 3); push(FELIZ, 1'b1, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL midreset_restore[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
    endtask

    task automatic test_button;
        logic [5:0] e;
        int idx;
        set_levels(2'd3, 2'd3, 2'd3, 2'd3);
        test_btn = 1'b1;
`ifdef MASCOTA_TEST_EN
        push(TRISTE, 1'b1, 1);
`else
        push(FELIZ, 1'b0, 1);
`endif
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL button_press[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
        test_btn = 1'b0;
`ifdef MASCOTA_TEST_EN
        push(TRISTE, 1'b0, 35); push(FELIZ, 1'b1, 1); push(FELIZ, 1'b0, 1);
`else
        push(FELIZ, 1'b0, 6);
`endif
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL button_after[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
    endtask

    task automatic test_muerto;
        logic [5:0] e;
        int idx;
        set_levels(2'd3, 2'd0, 2'd3, 2'd0);
        push(FELIZ, 1'b0, 3); push(ENFERMO, 1'b1, 1); push(ENFERMO, 1'b0, 11);
        push(MUERTO, 1'b1, 1); push(MUERTO, 1'b0, 1);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL muerto_enter[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
        set_levels(2'd3, 2'd3, 2'd3, 2'd3);
        test_btn = 1'b1;
        push(MUERTO, 1'b0, 3);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            test_btn = 1'b0;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL muerto_absorb[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
        push(MUERTO, 1'b0, 5);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL muerto_hold[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== ex(FELIZ, 1'b0)) begin
            n_bad++;
            $display("FAIL muerto_reset: got %b, expected %b", obs(), ex(FELIZ, 1'b0));
        end
        @(negedge clk) reset = 1'b1;
        push(FELIZ, 1'b0, 3);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL muerto_release[%0d]: got %b, expected %b", idx, obs(), e);
            end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_triste();
        test_glitch();
        test_dormido();
        test_enfermo_priority();
        test_back_to_back();
        test_reset_mid();
        test_button();
        test_muerto();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
